// File: rtl/u409_pkg.sv
// Shared types and PIO timing constants for the U409 ATA PIO sequencer.
// All counts are in CLK40 (40 MHz, 25 ns) cycles.
package u409_pkg;

  localparam int T1_PIO0       = 3;
  localparam int T2_PIO0       = 7;
  localparam int CYC_PIO0      = 24;
  localparam int T1_PIO4       = 1;
  localparam int T2_PIO4       = 3;
  localparam int CYC_PIO4      = 5;
  localparam int IORDY_TIMEOUT = 50;

  // Recovery fills the rest of the minimum cycle after SETUP, STROBE and the one HOLD cycle.
  localparam int REC_PIO0 = CYC_PIO0 - T1_PIO0 - T2_PIO0 - 1;
  localparam int REC_PIO4 = CYC_PIO4 - T1_PIO4 - T2_PIO4 - 1;

  localparam int CNT_W = $clog2(CYC_PIO0 + 1);
  localparam int TO_W  = $clog2(IORDY_TIMEOUT + 1);

  typedef logic [CNT_W-1:0] cnt_t;

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    STROBE,
    HOLD,
    RECOVER
  } state_t;

  typedef enum logic {
    PIO0 = 1'b0,
    PIO4 = 1'b1
  } mode_t;

endpackage

// File: rtl/u409_ata_timing.sv
// Combinational lookup from PIO mode to setup, strobe and recovery cycle counts.
// Further PIO modes only need another entry here and a wider mode_t.
module u409_ata_timing
  import u409_pkg::*;
(
  input  mode_t mode,
  output cnt_t  t1,
  output cnt_t  t2,
  output cnt_t  rec
);

  // NOTE: every output gets a value on every path through always_comb, otherwise a latch is inferred.
  always_comb begin
    t1  = cnt_t'(T1_PIO0);
    t2  = cnt_t'(T2_PIO0);
    rec = cnt_t'(REC_PIO0);
    case (mode)
      PIO4: begin
        t1  = cnt_t'(T1_PIO4);
        t2  = cnt_t'(T2_PIO4);
        rec = cnt_t'(REC_PIO4);
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/u409_ata_pio_sequencer.sv
// ATA PIO cycle sequencer: turns a CPU transfer start into timed DIORn/DIOWn strobes.
// Optional IORDY wait-state handling is compiled in with the ATA_IORDY_EN macro.
module u409_ata_pio_sequencer
  import u409_pkg::*;
(
  input  logic CLK40,
  input  logic RESETn,
  input  logic TSn,
  input  logic RnW,
  input  logic ATA_SPACE,
  input  logic SEC_SEL,
  input  logic PPIO,
  input  logic SPIO,
  input  logic IORDY,
  output logic DIORn,
  output logic DIOWn,
  output logic ATA_TACK,
  output logic ATA_BUSY,
  output logic ATA_TIMEOUT
);

  state_t state;
  cnt_t   cnt;
  logic   rnw_q;
  mode_t  mode_q;
  logic   pend;
  logic   pend_rnw;
  mode_t  pend_mode;
  logic   dior_n;
  logic   diow_n;
  logic   tack;
  logic   busy;

  cnt_t   t1;
  cnt_t   t2;
  cnt_t   rec;

  logic   start;
  mode_t  start_mode;
  logic   stretching;
  logic   last_next;
  logic   leave;

  assign start      = !TSn && ATA_SPACE;
  assign start_mode = mode_t'(SEC_SEL ? SPIO : PPIO);

  // Timing always follows the mode latched for the cycle in flight.
  u409_ata_timing u_timing (
    .mode (mode_q),
    .t1   (t1),
    .t2   (t2),
    .rec  (rec)
  );

`ifdef ATA_IORDY_EN
  logic             iordy_m;
  logic             iordy_s;
  logic             stretch;
  logic [TO_W-1:0]  scnt;
  logic             timeout;

  always_ff @(posedge CLK40) begin
    if (!RESETn) begin
      iordy_m <= 1'b0;
      iordy_s <= 1'b0;
    end else begin
      iordy_m <= IORDY;
      iordy_s <= iordy_m;
    end
  end

  assign stretching  = stretch;
  assign ATA_TIMEOUT = timeout;
`else
  logic unused_iordy;
  assign unused_iordy = IORDY;
  assign stretching   = 1'b0;
  assign ATA_TIMEOUT  = 1'b0;
`endif

  // last_next: the coming edge enters the final STROBE cycle, where ATA_TACK is due.
  always_comb begin
    last_next = 1'b0;
    leave     = 1'b0;
    case (state)
      SETUP:   last_next = (cnt == t1 - cnt_t'(1)) && (t2 == cnt_t'(1));
      STROBE:  last_next = !tack && !stretching && (cnt + cnt_t'(1) == t2 - cnt_t'(1));
      HOLD:    leave     = (rec == '0);
      RECOVER: leave     = (cnt == rec - cnt_t'(1));
      default: ;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge CLK40) begin
    if (!RESETn) begin
      state     <= IDLE;
      cnt       <= '0;
      rnw_q     <= 1'b0;
      mode_q    <= PIO0;
      pend      <= 1'b0;
      pend_rnw  <= 1'b0;
      pend_mode <= PIO0;
      dior_n    <= 1'b1;
      diow_n    <= 1'b1;
      tack      <= 1'b0;
      busy      <= 1'b0;
`ifdef ATA_IORDY_EN
      stretch   <= 1'b0;
      scnt      <= '0;
      timeout   <= 1'b0;
`endif
    end else begin
      if (start && state != IDLE) begin
        pend      <= 1'b1;
        pend_rnw  <= RnW;
        pend_mode <= start_mode;
      end

      case (state)
        IDLE: begin
          if (start) begin
            state  <= SETUP;
            cnt    <= '0;
            busy   <= 1'b1;
            rnw_q  <= RnW;
            mode_q <= start_mode;
          end
        end

        SETUP: begin
          if (cnt == t1 - cnt_t'(1)) begin
            state  <= STROBE;
            cnt    <= '0;
            dior_n <= !rnw_q;
            diow_n <= rnw_q;
          end else begin
            cnt <= cnt + cnt_t'(1);
          end
        end

        STROBE: begin
          if (tack) begin
            state  <= HOLD;
            cnt    <= '0;
            dior_n <= 1'b1;
            diow_n <= 1'b1;
            tack   <= 1'b0;
`ifdef ATA_IORDY_EN
            timeout <= 1'b0;
`endif
          end
`ifdef ATA_IORDY_EN
          else if (stretch) begin
            if (iordy_s) begin
              tack    <= 1'b1;
              stretch <= 1'b0;
            end else if (scnt == TO_W'(IORDY_TIMEOUT)) begin
              tack    <= 1'b1;
              timeout <= 1'b1;
              stretch <= 1'b0;
            end else begin
              scnt <= scnt + TO_W'(1);
            end
          end
`endif
          else begin
            cnt <= cnt + cnt_t'(1);
          end
        end

        HOLD, RECOVER: begin
          if (leave) begin
            if (start || pend) begin
              state  <= SETUP;
              cnt    <= '0;
              rnw_q  <= start ? RnW : pend_rnw;
              mode_q <= start ? start_mode : pend_mode;
              pend   <= 1'b0;
            end else begin
              state <= IDLE;
              busy  <= 1'b0;
            end
          end else if (state == HOLD) begin
            state <= RECOVER;
            cnt   <= '0;
          end else begin
            cnt <= cnt + cnt_t'(1);
          end
        end

        default: state <= IDLE;
      endcase

      if (last_next) begin
`ifdef ATA_IORDY_EN
        tack    <= iordy_s;
        stretch <= !iordy_s;
        scnt    <= TO_W'(1);
`else
        tack    <= 1'b1;
`endif
      end
    end
  end

  assign DIORn    = dior_n;
  assign DIOWn    = diow_n;
  assign ATA_TACK = tack;
  assign ATA_BUSY = busy;

endmodule

// File: tb/tb_u409_ata_pio_sequencer.sv
// Directed bench for the ATA PIO sequencer: captures each access cycle by cycle
// and compares strobe, ack and busy windows against hand-computed cycle numbers.
module tb_u409_ata_pio_sequencer;

  localparam int MAXC = 100;

  logic CLK40 = 1'b0;
  logic RESETn, TSn, RnW, ATA_SPACE, SEC_SEL, PPIO, SPIO, IORDY;
  logic DIORn, DIOWn, ATA_TACK, ATA_BUSY, ATA_TIMEOUT;

  // Cycle k (1-based) is the clock period that follows the k-th edge after the accept edge.
  logic [MAXC:1] cap_rd, cap_wr, cap_tk, cap_bz, cap_to;

  int checks = 0;
  int errors = 0;

  u409_ata_pio_sequencer dut (
    .CLK40       (CLK40),
    .RESETn      (RESETn),
    .TSn         (TSn),
    .RnW         (RnW),
    .ATA_SPACE   (ATA_SPACE),
    .SEC_SEL     (SEC_SEL),
    .PPIO        (PPIO),
    .SPIO        (SPIO),
    .IORDY       (IORDY),
    .DIORn       (DIORn),
    .DIOWn       (DIOWn),
    .ATA_TACK    (ATA_TACK),
    .ATA_BUSY    (ATA_BUSY),
    .ATA_TIMEOUT (ATA_TIMEOUT)
  );

  always #12 CLK40 = ~CLK40;

  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic int first_set(input logic [MAXC:1] v);
    for (int i = 1; i <= MAXC; i++) if (v[i]) return i;
    return 0;
  endfunction

  function automatic int last_set(input logic [MAXC:1] v);
    for (int i = MAXC; i >= 1; i--) if (v[i]) return i;
    return 0;
  endfunction

  // One access from cycle 0; optional second start in cycle c2, reset in cycle rst_c,
  // IORDY low in cycles lo_from..lo_to (each value is sampled at the end of its cycle).
  task automatic run(input int n, input bit rnw, input bit sec,
                     input int c2, input bit rnw2, input bit sec2,
                     input int rst_c, input int lo_from, input int lo_to);
    cap_rd = '1; cap_wr = '1; cap_tk = '0; cap_bz = '0; cap_to = '0;
    @(negedge CLK40);
    TSn = 1'b0; RnW = rnw; SEC_SEL = sec; ATA_SPACE = 1'b1;
    IORDY = !(lo_from == 0);
    @(posedge CLK40); #1;
    TSn = 1'b1; ATA_SPACE = 1'b0;
    for (int k = 1; k <= n; k++) begin
      cap_rd[k] = DIORn;
      cap_wr[k] = DIOWn;
      cap_tk[k] = ATA_TACK;
      cap_bz[k] = ATA_BUSY;
      cap_to[k] = ATA_TIMEOUT;
      if (k == rst_c + 1) RESETn = 1'b1;
      if (k == rst_c) RESETn = 1'b0;
      if (k == c2) begin
        TSn = 1'b0; RnW = rnw2; SEC_SEL = sec2; ATA_SPACE = 1'b1;
      end
      IORDY = !(k >= lo_from && k <= lo_to);
      @(posedge CLK40); #1;
      TSn = 1'b1; ATA_SPACE = 1'b0;
    end
    IORDY  = 1'b1;
    RESETn = 1'b1;
  endtask

  task automatic check_pio0_read(input string p);
    check({p, "_rd_first"}, first_set(~cap_rd), 4);
    check({p, "_rd_len"},   $countones(~cap_rd), 7);
    check({p, "_tack_at"},  first_set(cap_tk), 10);
    check({p, "_tack_num"}, $countones(cap_tk), 1);
    check({p, "_busy_len"}, $countones(cap_bz), 24);
    check({p, "_busy_end"}, last_set(cap_bz), 24);
    check({p, "_wr_len"},   $countones(~cap_wr), 0);
    check({p, "_to_num"},   $countones(cap_to), 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  initial begin
    RESETn = 1'b0; TSn = 1'b1; RnW = 1'b1; ATA_SPACE = 1'b0;
    SEC_SEL = 1'b0; PPIO = 1'b0; SPIO = 1'b1; IORDY = 1'b1;
    repeat (3) @(posedge CLK40);
    #1;
    check("rst_diorn",   int'(DIORn), 1);
    check("rst_diown",   int'(DIOWn), 1);
    check("rst_tack",    int'(ATA_TACK), 0);
    check("rst_busy",    int'(ATA_BUSY), 0);
    check("rst_timeout", int'(ATA_TIMEOUT), 0);
    @(negedge CLK40);
    RESETn = 1'b1;
    repeat (2) @(posedge CLK40);

    // Primary PIO0 read.
    run(30, 1'b1, 1'b0, 0, 1'b0, 1'b0, 0, MAXC + 1, MAXC + 1);
    check_pio0_read("p0rd");

    // Secondary PIO4 writes, second start in the HOLD cycle of the first.
    run(12, 1'b0, 1'b1, 5, 1'b0, 1'b1, 0, MAXC + 1, MAXC + 1);
    check("p4wr_low_2_4",  int'(cap_wr[4:2]), 0);
    check("p4wr_hold5",    int'(cap_wr[5]), 1);
    check("p4wr_setup6",   int'(cap_wr[6]), 1);
    check("p4wr_low_7_9",  int'(cap_wr[9:7]), 0);
    check("p4wr_wr_len",   $countones(~cap_wr), 6);
    check("p4wr_tack1",    first_set(cap_tk), 4);
    check("p4wr_tack2",    last_set(cap_tk), 9);
    check("p4wr_tack_num", $countones(cap_tk), 2);
    check("p4wr_busy_len", $countones(cap_bz), 10);
    check("p4wr_rd_len",   $countones(~cap_rd), 0);

    // PIO0 primary read, then a PIO4 secondary read started during RECOVER.
    run(35, 1'b1, 1'b0, 15, 1'b1, 1'b1, 0, MAXC + 1, MAXC + 1);
    check("mix_setup25",   int'(cap_rd[25]), 1);
    check("mix_rd2_start", int'(cap_rd[26]), 0);
    check("mix_rd_len",    $countones(~cap_rd), 10);
    check("mix_tack_num",  $countones(cap_tk), 2);
    check("mix_tack2",     last_set(cap_tk), 28);
    check("mix_busy_len",  $countones(cap_bz), 29);
    check("mix_busy_end",  last_set(cap_bz), 29);

    // Reset taken in the second STROBE cycle of a PIO0 read.
    run(15, 1'b1, 1'b0, 0, 1'b0, 1'b0, 5, MAXC + 1, MAXC + 1);
    check("rst_rd_len",    $countones(~cap_rd), 2);
    check("rst_rd6",       int'(cap_rd[6]), 1);
    check("rst_busy_end",  last_set(cap_bz), 5);
    check("rst_tack_num",  $countones(cap_tk), 0);

    run(30, 1'b1, 1'b0, 0, 1'b0, 1'b0, 0, MAXC + 1, MAXC + 1);
    check_pio0_read("after_rst");

`ifdef ATA_IORDY_EN
    // IORDY low for 20 cycles spanning the end of STROBE.
    run(50, 1'b1, 1'b0, 0, 1'b0, 1'b0, 0, 5, 24);
    check("ioe_rd_len",   $countones(~cap_rd), 25);
    check("ioe_rd_end",   last_set(~cap_rd), 28);
    check("ioe_tack_at",  first_set(cap_tk), 28);
    check("ioe_tack_num", $countones(cap_tk), 1);
    check("ioe_to_num",   $countones(cap_to), 0);
    check("ioe_busy_end", last_set(cap_bz), 42);

    // IORDY held low: forced ack with timeout after 50 stretch cycles.
    run(80, 1'b1, 1'b0, 0, 1'b0, 1'b0, 0, 0, MAXC);
    check("iot_rd_len",   $countones(~cap_rd), 57);
    check("iot_tack_at",  first_set(cap_tk), 60);
    check("iot_tack_num", $countones(cap_tk), 1);
    check("iot_to_at",    first_set(cap_to), 60);
    check("iot_to_num",   $countones(cap_to), 1);
    check("iot_busy_end", last_set(cap_bz), 74);
`else
    // IORDY is ignored in this build.
    run(30, 1'b1, 1'b0, 0, 1'b0, 1'b0, 0, 0, MAXC);
    check_pio0_read("iordy_low");
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
